// File: rtl/sa_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic multiplier sequencer.
package sa_ctrl_pkg;

    localparam int SIZE_DEF       = 8;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int DRAIN_CYC_DEF  = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FEED  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        FEED  = ST_FEED,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } sa_state_t;

    function automatic int idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Feed counter must reach 2*SIZE-2 without wrapping.
    function automatic int cnt_width(input int size);
        return $clog2(2 * size);
    endfunction

endpackage

// File: rtl/sa_skew_mux.sv
// Picks element (t - lane) of a buffered row/column, or zero when that
// index falls outside the matrix; this produces one lane of the wavefront.
module sa_skew_mux
    import sa_ctrl_pkg::*;
#(
    parameter int SIZE       = SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CW         = cnt_width(SIZE),
    parameter int IW         = idx_width(SIZE)
) (
    input  logic [SIZE*DATA_WIDTH-1:0] vec,
    input  logic [CW-1:0]              t,
    input  logic [IW-1:0]              lane,
    input  logic                       en,
    output logic [DATA_WIDTH-1:0]      elem
);

    // One extra bit so t < lane wraps to a value no valid index can match.
    logic [CW:0] diff;

    assign diff = {1'b0, t} - {{(CW + 1 - IW){1'b0}}, lane};

    always_comb begin
        elem = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (en && diff == (CW + 1)'(k)) begin
                elem = vec[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the output-stationary systolic multiplier: buffers A/B, clears
// the array, feeds the skewed wavefront, drains, and hands C out. Optional
// performance counters are enabled with SA_PERF_CNT_EN.
//
// state | meaning
// IDLE  | accept load beats, wait for start
// CLEAR | one-cycle array clear (arr_rst_n low)
// FEED  | drive skewed operands, t = 0 .. 2*SIZE-2
// DRAIN | zeros in while the pipeline settles; capture C on last cycle
// DONE  | hold result until res_ready
module systolic_seq_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int SIZE       = SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DRAIN_CYC  = DRAIN_CYC_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic                             ld_sel,
    input  logic [$clog2(SIZE)-1:0]          ld_row,
    input  logic [SIZE*DATA_WIDTH-1:0]       ld_data,
    input  logic                             start,
    output logic                             busy,
    output logic                             arr_rst_n,
    output logic [SIZE*DATA_WIDTH-1:0]       arr_a,
    output logic [SIZE*DATA_WIDTH-1:0]       arr_b,
    input  logic [SIZE*SIZE*2*DATA_WIDTH-1:0] arr_c,
    output logic                             res_valid,
    input  logic                             res_ready,
`ifdef SA_PERF_CNT_EN
    output logic [31:0]                      perf_cycles,
    output logic [31:0]                      perf_stall,
`endif
    output logic [SIZE*SIZE*2*DATA_WIDTH-1:0] res_c
);

    localparam int CW  = cnt_width(SIZE);
    localparam int IW  = idx_width(SIZE);
    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CW-1:0]  T_LAST = CW'(2 * SIZE - 2);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYC - 1);

    sa_state_t state;
    logic [CW-1:0]  t_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           feeding;
    logic           drain_last;

    logic [SIZE*DATA_WIDTH-1:0] a_rows [SIZE];
    logic [SIZE*DATA_WIDTH-1:0] b_rows [SIZE];
    logic [SIZE*DATA_WIDTH-1:0] b_cols [SIZE];

    assign ld_ready   = (state == IDLE) && !start;
    assign feeding    = (state == FEED);
    assign drain_last = (drain_cnt == D_LAST);

    // Operand buffers survive reset so a run can be repeated after an abort.
    always_ff @(posedge clk) begin
        if (!rst && ld_valid && ld_ready) begin
            if (ld_sel) begin
                b_rows[ld_row] <= ld_data;
            end else begin
                a_rows[ld_row] <= ld_data;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < SIZE; j++) begin
            b_cols[j] = '0;
            for (int k = 0; k < SIZE; k++) begin
                b_cols[j][k*DATA_WIDTH +: DATA_WIDTH] = b_rows[k][j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        sa_skew_mux #(
            .SIZE       (SIZE),
            .DATA_WIDTH (DATA_WIDTH),
            .CW         (CW),
            .IW         (IW)
        ) u_mux_a (
            .vec  (a_rows[i]),
            .t    (t_cnt),
            .lane (IW'(i)),
            .en   (feeding),
            .elem (arr_a[i*DATA_WIDTH +: DATA_WIDTH])
        );

        sa_skew_mux #(
            .SIZE       (SIZE),
            .DATA_WIDTH (DATA_WIDTH),
            .CW         (CW),
            .IW         (IW)
        ) u_mux_b (
            .vec  (b_cols[i]),
            .t    (t_cnt),
            .lane (IW'(i)),
            .en   (feeding),
            .elem (arr_b[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t_cnt     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            arr_rst_n <= 1'b0;
            res_valid <= 1'b0;
            res_c     <= '0;
        end else begin
            arr_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        arr_rst_n <= 1'b0;
                    end
                end
                CLEAR: begin
                    state <= FEED;
                    t_cnt <= '0;
                end
                FEED: begin
                    if (t_cnt == T_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        res_c     <= arr_c;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SA_PERF_CNT_EN
    logic [31:0] run_cnt;

    // perf_cycles counts edges from the accepting edge to the res_valid edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt     <= '0;
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (state == IDLE && start) begin
                run_cnt    <= '0;
                perf_stall <= '0;
            end else if (state inside {CLEAR, FEED, DRAIN}) begin
                run_cnt <= run_cnt + 32'd1;
            end
            if (state == DRAIN && drain_last) begin
                perf_cycles <= run_cnt + 32'd1;
            end
            if (state == DONE && !res_ready && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
